// File: rtl/branch_select_unit_if.sv
// Purpose: flag/control bundle between the control unit and the next-PC
//          source selector, plus the resulting PC-mux select.
// Signals:
//   Carry    - ALU carry flag
//   BCD      - ALU BCD-adjust/condition flag
//   BrFlag   - branch enable from the control unit
//   PCUpdate - 3-bit PC-update class code
//   PCSel    - 2-bit PC mux select (00 seq, 01 branch, 10 reg/jump, 11 hold)
//   Taken    - 1 when PCSel is non-sequential
// Modports: master = control/datapath side, slave = branch_select_unit.
interface branch_select_unit_if;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned SEL_W  = 2;

  logic              Carry;
  logic              BCD;
  logic              BrFlag;
  logic [CODE_W-1:0] PCUpdate;
  logic [SEL_W-1:0]  PCSel;
  logic              Taken;

  modport master (
    output Carry,
    output BCD,
    output BrFlag,
    output PCUpdate,
    input  PCSel,
    input  Taken
  );

  modport slave (
    input  Carry,
    input  BCD,
    input  BrFlag,
    input  PCUpdate,
    output PCSel,
    output Taken
  );
endinterface

// File: rtl/branch_select_unit.sv
// Purpose: next-PC source selector for the KGP-RISC datapath. Decodes the
//          PC-update class code with the branch enable and ALU flags into the
//          PC mux select.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset (unused when REGISTERED = 0)
//   bus   - slave side of branch_select_unit_if (flags in, PCSel/Taken out)
// Parameters:
//   REGISTERED - 1: PCSel/Taken registered, 1-cycle latency
//                0: PCSel/Taken driven straight from the decode
module branch_select_unit #(
  parameter bit REGISTERED = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  branch_select_unit_if.slave      bus
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned SEL_W  = 2;

  localparam logic [CODE_W-1:0] CODE_SEQ   = 3'b000;
  localparam logic [CODE_W-1:0] CODE_BR    = 3'b001;
  localparam logic [CODE_W-1:0] CODE_BRC   = 3'b010;
  localparam logic [CODE_W-1:0] CODE_JREG  = 3'b011;
  localparam logic [CODE_W-1:0] CODE_HOLD  = 3'b100;

  localparam logic [SEL_W-1:0] SEL_SEQ    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] SEL_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] SEL_HOLD   = 2'b11;

  logic [SEL_W-1:0] sel_next_c;
  logic             taken_next_c;
  logic             bcd_unused_c;

  // BCD participates in no current PC-update code; kept on the bus for
  // future conditional-branch encodings.
  assign bcd_unused_c = bus.BCD;

  // Next-PC source decode; reserved or unknown codes fall to sequential.
  always_comb begin
    sel_next_c = SEL_SEQ;
    case (bus.PCUpdate)
      CODE_SEQ:  sel_next_c = SEL_SEQ;
      CODE_BR:   sel_next_c = bus.BrFlag ? SEL_BRANCH : SEL_SEQ;
      CODE_BRC:  sel_next_c = (bus.BrFlag && bus.Carry) ? SEL_BRANCH : SEL_SEQ;
      CODE_JREG: sel_next_c = bus.BrFlag ? SEL_JUMP : SEL_SEQ;
      CODE_HOLD: sel_next_c = SEL_HOLD;
      default:   sel_next_c = SEL_SEQ;
    endcase
  end

  assign taken_next_c = (sel_next_c != SEL_SEQ);

  generate
    if (REGISTERED) begin : g_reg
      logic [SEL_W-1:0] pc_sel_q;
      logic             taken_q;

      // Output registers; reset clears them asynchronously and discards
      // whatever decode was pending.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pc_sel_q <= SEL_SEQ;
          taken_q  <= 1'b0;
        end else begin
          pc_sel_q <= sel_next_c;
          taken_q  <= taken_next_c;
        end
      end

      assign bus.PCSel = pc_sel_q;
      assign bus.Taken = taken_q;
    end else begin : g_comb
      assign bus.PCSel = sel_next_c;
      assign bus.Taken = taken_next_c;
    end
  endgenerate

endmodule

// File: tb/tb_branch_select_unit.sv
// Purpose: self-checking bench for branch_select_unit (REGISTERED = 1).
//          Directed reset/sweep/flag cases plus randomized traffic compared
//          against a behavioural next-PC model.
module tb_branch_select_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  branch_select_unit_if bus ();

  branch_select_unit #(.REGISTERED(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: which PC source the instruction class asks for.
  function automatic logic [1:0] ref_sel(input logic [2:0] code,
                                         input logic br, input logic c);
    int k;
    k = int'(code);
    if (k == 4) return 2'd3;          // hold always wins
    if (k > 4 || k == 0) return 2'd0; // reserved / sequential
    if (!br) return 2'd0;             // branches need enable
    if (k == 1) return 2'd1;
    if (k == 2) return c ? 2'd1 : 2'd0;
    return 2'd2;                      // k == 3
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] code, input logic br,
                       input logic c, input logic b);
    bus.PCUpdate = code;
    bus.BrFlag   = br;
    bus.Carry    = c;
    bus.BCD      = b;
  endtask

  // Apply inputs just after an edge, check one edge later.
  task automatic step(input string tag, input logic [2:0] code,
                      input logic br, input logic c, input logic b,
                      input logic [1:0] exp);
    drive(code, br, c, b);
    @(posedge clk);
    #1;
    check({tag, "_sel"}, 32'(bus.PCSel), 32'(exp));
    check({tag, "_taken"}, 32'(bus.Taken), 32'(exp != 2'd0));
  endtask

  initial begin
    logic [2:0] code;
    logic br, c, b;
    logic [1:0] exp, prev;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(3'b100, 1'b1, 1'b1, 1'b1);

    // Reset holds outputs low across edges even with a hold request.
    #1;
    check("rst_sel0", 32'(bus.PCSel), 32'd0);
    check("rst_taken0", 32'(bus.Taken), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_sel_hold", 32'(bus.PCSel), 32'd0);
      check("rst_taken_hold", 32'(bus.Taken), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_sel", 32'(bus.PCSel), 32'd3);
    check("rst_release_taken", 32'(bus.Taken), 32'd1);

    // Code sweep.
    step("sweep000", 3'b000, 1'b1, 1'b0, 1'b0, 2'b00);
    step("sweep001", 3'b001, 1'b1, 1'b0, 1'b0, 2'b01);
    step("sweep010", 3'b010, 1'b1, 1'b0, 1'b0, 2'b00);
    step("sweep011", 3'b011, 1'b1, 1'b0, 1'b0, 2'b10);
    step("sweep100", 3'b100, 1'b1, 1'b0, 1'b0, 2'b11);

    // Carry/BCD matrix on branch-on-carry.
    step("bc_c0b0", 3'b010, 1'b1, 1'b0, 1'b0, 2'b00);
    step("bc_c1b0", 3'b010, 1'b1, 1'b1, 1'b0, 2'b01);
    step("bc_c0b1", 3'b010, 1'b1, 1'b0, 1'b1, 2'b00);
    step("bc_c1b1", 3'b010, 1'b1, 1'b1, 1'b1, 2'b01);

    // BrFlag gating.
    step("gate001", 3'b001, 1'b0, 1'b1, 1'b0, 2'b00);
    step("gate010", 3'b010, 1'b0, 1'b1, 1'b0, 2'b00);
    step("gate011", 3'b011, 1'b0, 1'b1, 1'b0, 2'b00);
    step("gate100", 3'b100, 1'b0, 1'b1, 1'b1, 2'b11);

    // Reserved codes.
    step("rsv101", 3'b101, 1'b1, 1'b1, 1'b1, 2'b00);
    step("rsv110", 3'b110, 1'b1, 1'b1, 1'b1, 2'b00);
    step("rsv111", 3'b111, 1'b1, 1'b1, 1'b1, 2'b00);

    // Latency: output must not move before the edge.
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    #2;
    check("lat_before_edge", 32'(bus.PCSel), 32'd0);
    @(posedge clk);
    #1;
    check("lat_after_edge", 32'(bus.PCSel), 32'd1);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", 32'(bus.PCSel), 32'd0);
    check("async_rst_taken", 32'(bus.Taken), 32'd0);
    @(posedge clk);
    #1;
    check("async_rst_edge", 32'(bus.PCSel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic, with a mid-cycle input wiggle that must be ignored.
    for (int i = 0; i < 400; i++) begin
      code = 3'($urandom_range(0, 7));
      br   = 1'($urandom);
      c    = 1'($urandom);
      b    = 1'($urandom);
      exp  = ref_sel(code, br, c);
      drive(code, br, c, b);
      @(posedge clk);
      #1;
      check("rnd_sel", 32'(bus.PCSel), 32'(exp));
      check("rnd_taken", 32'(bus.Taken), 32'(exp != 2'd0));
      prev = exp;
      drive(3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #2;
      check("rnd_stable", 32'(bus.PCSel), 32'(prev));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
